line_mem_arbiter: RTL and testbench

Parametrised successor to the single-ICache/DCache memory front end. Arbitrates NUM_PORTS cache-line ports and one uncached IO port onto the byte-serial RAM bus. Line transfers are BLOCK_SIZE-byte fills or writebacks; IO transfers are 1/2/4 bytes. Adds configurable port count, selectable arbitration, UART-full stall and read abort on branch flush.

---
 rtl/line_mem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_line_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_arbiter.sv
// Arbitrates NUM_PORTS cache-line ports plus one uncached IO port onto the byte-serial RAM bus.
// Optional define ARB_ROUND_ROBIN_EN selects round-robin line-port arbitration (fixed priority otherwise).
module line_mem_arbiter #(
  parameter int unsigned BLOCK_WIDTH   = 4,
  parameter int unsigned BLOCK_SIZE    = 2**BLOCK_WIDTH,
  parameter int unsigned NUM_PORTS     = 2,
  parameter logic [31:0] IO_STALL_ADDR = 32'h00030000
) (
  input  logic                                  clkIn,
  input  logic                                  resetIn,
  input  logic                                  clearIn,
  input  logic [NUM_PORTS-1:0]                  lineReqIn,
  input  logic [NUM_PORTS-1:0]                  lineWriteIn,
  input  logic [NUM_PORTS*(32-BLOCK_WIDTH)-1:0] lineAddrIn,
  input  logic [NUM_PORTS*BLOCK_SIZE*8-1:0]     lineDataIn,
  output logic [NUM_PORTS-1:0]                  lineDoneOut,
  output logic [BLOCK_SIZE*8-1:0]               lineDataOut,
  input  logic                                  ioReqIn,
  input  logic                                  ioWriteIn,
  input  logic [1:0]                            ioSizeIn,
  input  logic [31:0]                           ioAddrIn,
  input  logic [31:0]                           ioDataIn,
  output logic                                  ioDoneOut,
  output logic [31:0]                           ioDataOut,
  input  logic                                  ioBufferFullIn,
  input  logic [7:0]                            memIn,
  output logic [31:0]                           memAddr,
  output logic [7:0]                            memOut,
  output logic                                  readWriteOut
);

  localparam int unsigned LADDR_W = 32 - BLOCK_WIDTH;
  localparam int unsigned LINE_W  = BLOCK_SIZE * 8;
  localparam int unsigned CNT_W   = BLOCK_WIDTH + 1;
  localparam int unsigned PORT_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {IDLE, LINE_RD, LINE_WR, IO_RD, IO_WR, DONE} state_t;

  state_t               state, stateNxt;
  logic [CNT_W-1:0]     cnt, cntNxt;
  logic [CNT_W-1:0]     len, lenNxt;
  logic [31:0]          base, baseNxt;
  logic [PORT_W-1:0]    port, portNxt;
  logic [LINE_W-1:0]    dataBuf, dataBufNxt;
  logic [NUM_PORTS-1:0] lineDoneNxt;
  logic [LINE_W-1:0]    lineDataNxt;
  logic                 ioDoneNxt;
  logic [31:0]          ioDataNxt;
  logic [31:0]          memAddrNxt;
  logic [7:0]           memOutNxt;
  logic                 rwNxt;

  logic                 ioValid;
  logic [CNT_W-1:0]     ioLen;
  logic [NUM_PORTS-1:0] lineElig;
  logic                 lineHit;
  logic [PORT_W-1:0]    lineSel;
  int unsigned          arbIdx;
  logic                 lineWrSel;
  logic [LADDR_W-1:0]   lineAddrSel;
  logic [LINE_W-1:0]    lineDataSel;

`ifdef ARB_ROUND_ROBIN_EN
  logic [PORT_W-1:0]    rrPtr, rrPtrNxt;
`endif

  // Request qualification and line-port selection; a flush masks read requests for the cycle.
  always_comb begin
    ioValid  = ioReqIn && (ioSizeIn != 2'b00)
               && !(ioWriteIn && ioBufferFullIn && (ioAddrIn == IO_STALL_ADDR))
               && !(clearIn && !ioWriteIn);
    lineElig = lineReqIn & (lineWriteIn | {NUM_PORTS{~clearIn}});
    lineHit  = 1'b0;
    lineSel  = '0;
    arbIdx   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      arbIdx = (32'(rrPtr) + k) % NUM_PORTS;
`else
      arbIdx = k;
`endif
      if (!lineHit && lineElig[PORT_W'(arbIdx)]) begin
        lineHit = 1'b1;
        lineSel = PORT_W'(arbIdx);
      end
    end
    lineWrSel   = 1'b0;
    lineAddrSel = '0;
    lineDataSel = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (PORT_W'(k) == lineSel) begin
        lineWrSel   = lineWriteIn[k];
        lineAddrSel = lineAddrIn[k*LADDR_W +: LADDR_W];
        lineDataSel = lineDataIn[k*LINE_W +: LINE_W];
      end
    end
    case (ioSizeIn)
      2'b01:   ioLen = CNT_W'(1);
      2'b10:   ioLen = CNT_W'(2);
      default: ioLen = CNT_W'(4);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    lenNxt      = len;
    baseNxt     = base;
    portNxt     = port;
    dataBufNxt  = dataBuf;
    lineDoneNxt = '0;
    lineDataNxt = lineDataOut;
    ioDoneNxt   = 1'b0;
    ioDataNxt   = ioDataOut;
    memAddrNxt  = memAddr;
    memOutNxt   = memOut;
    rwNxt       = readWriteOut;
`ifdef ARB_ROUND_ROBIN_EN
    rrPtrNxt    = rrPtr;
`endif

    case (state)
      IDLE: begin
        if (ioValid) begin
          stateNxt   = ioWriteIn ? IO_WR : IO_RD;
          cntNxt     = '0;
          lenNxt     = ioLen;
          baseNxt    = ioAddrIn;
          dataBufNxt = ioWriteIn ? LINE_W'(ioDataIn) : '0;
          memAddrNxt = ioAddrIn;
          memOutNxt  = ioWriteIn ? ioDataIn[7:0] : memOut;
          rwNxt      = !ioWriteIn;
        end else if (lineHit) begin
          stateNxt   = lineWrSel ? LINE_WR : LINE_RD;
          cntNxt     = '0;
          lenNxt     = CNT_W'(BLOCK_SIZE);
          baseNxt    = {lineAddrSel, BLOCK_WIDTH'(0)};
          portNxt    = lineSel;
          dataBufNxt = lineWrSel ? lineDataSel : '0;
          memAddrNxt = {lineAddrSel, BLOCK_WIDTH'(0)};
          memOutNxt  = lineWrSel ? lineDataSel[7:0] : memOut;
          rwNxt      = !lineWrSel;
`ifdef ARB_ROUND_ROBIN_EN
          rrPtrNxt   = PORT_W'((32'(lineSel) + 32'd1) % NUM_PORTS);
`endif
        end
      end

      // Byte cnt-1 arrives on memIn in cycle cnt; result is presented one edge after the last capture.
      LINE_RD, IO_RD: begin
        if (clearIn) begin
          stateNxt = IDLE;
          rwNxt    = 1'b1;
        end else begin
          for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
            if ((cnt <= len) && (cnt == CNT_W'(b + 1))) dataBufNxt[b*8 +: 8] = memIn;
          end
          if ((cnt + CNT_W'(1)) < len) memAddrNxt = base + 32'(cnt) + 32'd1;
          if (cnt == (len + CNT_W'(1))) begin
            stateNxt = DONE;
            if (state == LINE_RD) begin
              lineDoneNxt = NUM_PORTS'(1) << port;
              lineDataNxt = dataBuf;
            end else begin
              ioDoneNxt = 1'b1;
              ioDataNxt = dataBuf[31:0];
            end
          end else begin
            cntNxt = cnt + CNT_W'(1);
          end
        end
      end

      // One write per cycle; the bus goes back to read for the cycle before the done pulse.
      LINE_WR, IO_WR: begin
        if ((cnt + CNT_W'(1)) < len) begin
          memAddrNxt = base + 32'(cnt) + 32'd1;
          rwNxt      = 1'b0;
          for (int unsigned b = 0; b < BLOCK_SIZE; b++) begin
            if (CNT_W'(b) == (cnt + CNT_W'(1))) memOutNxt = dataBuf[b*8 +: 8];
          end
        end else begin
          rwNxt = 1'b1;
        end
        if (cnt == len) begin
          stateNxt = DONE;
          if (state == LINE_WR) lineDoneNxt = NUM_PORTS'(1) << port;
          else                  ioDoneNxt   = 1'b1;
        end else begin
          cntNxt = cnt + CNT_W'(1);
        end
      end

      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      state        <= IDLE;
      cnt          <= '0;
      len          <= '0;
      base         <= '0;
      port         <= '0;
      dataBuf      <= '0;
      lineDoneOut  <= '0;
      lineDataOut  <= '0;
      ioDoneOut    <= 1'b0;
      ioDataOut    <= '0;
      memAddr      <= '0;
      memOut       <= '0;
      readWriteOut <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      rrPtr        <= '0;
`endif
    end else begin
      state        <= stateNxt;
      cnt          <= cntNxt;
      len          <= lenNxt;
      base         <= baseNxt;
      port         <= portNxt;
      dataBuf      <= dataBufNxt;
      lineDoneOut  <= lineDoneNxt;
      lineDataOut  <= lineDataNxt;
      ioDoneOut    <= ioDoneNxt;
      ioDataOut    <= ioDataNxt;
      memAddr      <= memAddrNxt;
      memOut       <= memOutNxt;
      readWriteOut <= rwNxt;
`ifdef ARB_ROUND_ROBIN_EN
      rrPtr        <= rrPtrNxt;
`endif
    end
  end

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed self-checking bench for line_mem_arbiter with a one-cycle-latency RAM model.
module tb_line_mem_arbiter;

  localparam int unsigned BW = 4;
  localparam int unsigned BS = 16;
  localparam int unsigned NP = 2;

  logic                   clkIn, resetIn, clearIn;
  logic [NP-1:0]          lineReqIn, lineWriteIn, lineDoneOut;
  logic [NP*(32-BW)-1:0]  lineAddrIn;
  logic [NP*BS*8-1:0]     lineDataIn;
  logic [BS*8-1:0]        lineDataOut;
  logic                   ioReqIn, ioWriteIn, ioDoneOut, ioBufferFullIn;
  logic [1:0]             ioSizeIn;
  logic [31:0]            ioAddrIn, ioDataIn, ioDataOut, memAddr;
  logic [7:0]             memIn, memOut;
  logic                   readWriteOut;

  int nCompared = 0;
  int nMismatched = 0;
  int wrCount = 0;
  logic [7:0] wmem [logic [31:0]];

  line_mem_arbiter dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .lineReqIn(lineReqIn), .lineWriteIn(lineWriteIn), .lineAddrIn(lineAddrIn),
    .lineDataIn(lineDataIn), .lineDoneOut(lineDoneOut), .lineDataOut(lineDataOut),
    .ioReqIn(ioReqIn), .ioWriteIn(ioWriteIn), .ioSizeIn(ioSizeIn), .ioAddrIn(ioAddrIn),
    .ioDataIn(ioDataIn), .ioDoneOut(ioDoneOut), .ioDataOut(ioDataOut),
    .ioBufferFullIn(ioBufferFullIn), .memIn(memIn), .memAddr(memAddr),
    .memOut(memOut), .readWriteOut(readWriteOut)
  );

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // RAM: byte at address a reads as 0xA0 + a[7:0], returned one cycle later.
  always @(posedge clkIn) memIn <= 8'hA0 + memAddr[7:0];

  // Write log, sampled mid-cycle.
  always @(negedge clkIn) begin
    if (resetIn && readWriteOut === 1'b0) begin
      wrCount <= wrCount + 1;
      wmem[memAddr] = memOut;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for the next done pulse; lat counts edges from the first edge seen (k=0).
  task automatic waitDone(output int lat, output logic [NP-1:0] lv, output logic iv);
    bit seen;
    seen = 0;
    lat = -1;
    lv = '0;
    iv = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (!seen) begin
        @(posedge clkIn);
        #1;
        if (lineDoneOut != '0 || ioDoneOut) begin
          seen = 1;
          lat = k;
          lv = lineDoneOut;
          iv = ioDoneOut;
        end
      end
    end
  endtask

  task automatic checkReset(input string pfx);
    check({pfx, "_lineDone"}, 128'(lineDoneOut), 128'd0);
    check({pfx, "_ioDone"}, 128'(ioDoneOut), 128'd0);
    check({pfx, "_lineData"}, lineDataOut, 128'd0);
    check({pfx, "_ioData"}, 128'(ioDataOut), 128'd0);
    check({pfx, "_memAddr"}, 128'(memAddr), 128'd0);
    check({pfx, "_memOut"}, 128'(memOut), 128'd0);
    check({pfx, "_rw"}, 128'(readWriteOut), 128'd1);
  endtask

  int lat, bad, wrBase, dones;
  logic [NP-1:0] lv;
  logic iv;
  logic [BS*8-1:0] expLine, wbData;
  logic [1:0]  ldSize [3];
  logic [31:0] ldAddr [3];
  logic [31:0] ldExp  [3];
  int          ldLat  [3];
  logic [NP-1:0] rrExp;

  initial begin
    resetIn = 1'b1; clearIn = 1'b0;
    lineReqIn = '0; lineWriteIn = '0; lineAddrIn = '0; lineDataIn = '0;
    ioReqIn = 1'b0; ioWriteIn = 1'b0; ioSizeIn = 2'b00; ioAddrIn = '0; ioDataIn = '0;
    ioBufferFullIn = 1'b0;
    for (int i = 0; i < BS; i++) begin
      expLine[i*8 +: 8] = 8'hA0 + 8'(i);
      wbData[i*8 +: 8]  = 8'(i);
    end
    #2 resetIn = 1'b0;
    repeat (2) @(posedge clkIn);
    #1 checkReset("rst");
    @(negedge clkIn) resetIn = 1'b1;

    // 1: port-0 fill at 0x100
    repeat (2) @(negedge clkIn);
    lineAddrIn[27:0] = 28'h0000010;
    lineReqIn = 2'b01;
    bad = 0; lat = -1; lv = '0;
    for (int k = 0; k < 60; k++) begin
      if (lat < 0) begin
        @(posedge clkIn);
        #1;
        if (k < 16 && (memAddr !== 32'h100 + 32'(k) || readWriteOut !== 1'b1)) bad++;
        if (lineDoneOut != '0) begin lat = k; lv = lineDoneOut; end
      end
    end
    lineReqIn = '0;
    check("t1_addrseq", 128'(bad), 128'd0);
    check("t1_latency", 128'(lat), 128'd18);
    check("t1_doneVec", 128'(lv), 128'b01);
    check("t1_byte15", 128'(lineDataOut[127:120]), 128'hAF);
    check("t1_line", lineDataOut, expLine);
    @(posedge clkIn);
    #1 check("t1_pulse", 128'(lineDoneOut), 128'd0);

    // 2: port-1 writeback at 0x200
    repeat (2) @(negedge clkIn);
    wrBase = wrCount;
    lineAddrIn[55:28] = 28'h0000020;
    lineDataIn[255:128] = wbData;
    lineWriteIn = 2'b10;
    lineReqIn = 2'b10;
    waitDone(lat, lv, iv);
    lineReqIn = '0;
    check("t2_latency", 128'(lat), 128'd17);
    check("t2_doneVec", 128'(lv), 128'b10);
    check("t2_rwInDone", 128'(readWriteOut), 128'd1);
    check("t2_writes", 128'(wrCount - wrBase), 128'd16);
    bad = 0;
    for (int i = 0; i < BS; i++)
      if (!wmem.exists(32'h200 + 32'(i)) || wmem[32'h200 + 32'(i)] !== 8'(i)) bad++;
    check("t2_data", 128'(bad), 128'd0);
    lineWriteIn = '0;

    // 3: IO word load beats a simultaneous port-0 fill
    repeat (2) @(negedge clkIn);
    ioReqIn = 1'b1; ioWriteIn = 1'b0; ioSizeIn = 2'b11; ioAddrIn = 32'h00030004;
    lineReqIn = 2'b01;
    waitDone(lat, lv, iv);
    ioReqIn = 1'b0;
    check("t3_ioFirst", 128'({iv, lv}), 128'b100);
    check("t3_ioLatency", 128'(lat), 128'd6);
    check("t3_ioData", 128'(ioDataOut), 128'hA7A6A5A4);
    waitDone(lat, lv, iv);
    lineReqIn = '0;
    check("t3_fillLatency", 128'(lat), 128'd19);
    check("t3_fillVec", 128'(lv), 128'b01);

    // IO loads: byte, half, half wrapping past 0xFFFFFFFF
    ldSize = '{2'b01, 2'b10, 2'b10};
    ldAddr = '{32'h00030001, 32'h00030002, 32'hFFFFFFFF};
    ldExp  = '{32'h000000A1, 32'h0000A3A2, 32'h0000A09F};
    ldLat  = '{3, 4, 4};
    for (int t = 0; t < 3; t++) begin
      repeat (2) @(negedge clkIn);
      ioReqIn = 1'b1; ioSizeIn = ldSize[t]; ioAddrIn = ldAddr[t];
      waitDone(lat, lv, iv);
      ioReqIn = 1'b0;
      check($sformatf("ld%0d_latency", t), 128'(lat), 128'(ldLat[t]));
      check($sformatf("ld%0d_data", t), 128'({iv, ioDataOut}), {95'd0, 1'b1, ldExp[t]});
    end

    // 4: stalled UART store lets a port-1 fill through, then issues
    repeat (2) @(negedge clkIn);
    ioReqIn = 1'b1; ioWriteIn = 1'b1; ioSizeIn = 2'b01; ioAddrIn = 32'h00030000;
    ioDataIn = 32'h00000041; ioBufferFullIn = 1'b1;
    lineReqIn = 2'b10;
    repeat (5) @(posedge clkIn);
    @(negedge clkIn) ioBufferFullIn = 1'b0;
    waitDone(lat, lv, iv);
    lineReqIn = '0;
    check("t4_fillFirst", 128'({iv, lv}), 128'b010);
    check("t4_fillLatency", 128'(lat), 128'd13);
    check("t4_fillData", lineDataOut, expLine);
    wrBase = wrCount;
    waitDone(lat, lv, iv);
    ioReqIn = 1'b0; ioWriteIn = 1'b0;
    check("t4_storeDone", 128'({iv, lv}), 128'b100);
    check("t4_storeLatency", 128'(lat), 128'd3);
    check("t4_writes", 128'(wrCount - wrBase), 128'd1);
    check("t4_uart", 128'(wmem.exists(32'h00030000) ? wmem[32'h00030000] : 8'h00), 128'h41);

    // 5a: flush at byte 7 of a port-0 fill
    repeat (2) @(negedge clkIn);
    lineReqIn = 2'b01;
    repeat (8) @(posedge clkIn);
    #1 check("t5a_addr7", 128'(memAddr), 128'h107);
    @(negedge clkIn);
    clearIn = 1'b1; lineReqIn = '0;
    @(posedge clkIn);
    #1 clearIn = 1'b0;
    check("t5a_rw", 128'(readWriteOut), 128'd1);
    dones = (lineDoneOut != '0) ? 1 : 0;
    repeat (25) begin
      @(posedge clkIn);
      #1 if (lineDoneOut != '0 || ioDoneOut) dones++;
    end
    check("t5a_noDone", 128'(dones), 128'd0);

    // 5b: flush and request drop during a writeback do not abort it
    repeat (2) @(negedge clkIn);
    wrBase = wrCount;
    lineAddrIn[55:28] = 28'h0000040;
    lineWriteIn = 2'b10; lineReqIn = 2'b10;
    @(posedge clkIn);
    @(negedge clkIn) clearIn = 1'b1;
    @(posedge clkIn);
    @(negedge clkIn);
    clearIn = 1'b0; lineReqIn = '0;
    waitDone(lat, lv, iv);
    lineWriteIn = '0;
    check("t5b_latency", 128'(lat), 128'd15);
    check("t5b_doneVec", 128'(lv), 128'b10);
    check("t5b_writes", 128'(wrCount - wrBase), 128'd16);
    bad = 0;
    for (int i = 0; i < BS; i++)
      if (!wmem.exists(32'h400 + 32'(i)) || wmem[32'h400 + 32'(i)] !== 8'(i)) bad++;
    check("t5b_data", 128'(bad), 128'd0);

    // 6: both ports requesting continuously
    repeat (2) @(negedge clkIn);
    lineAddrIn[27:0] = 28'h0000010; lineAddrIn[55:28] = 28'h0000020;
    lineReqIn = 2'b11;
    for (int n = 0; n < 4; n++) begin
      waitDone(lat, lv, iv);
`ifdef ARB_ROUND_ROBIN_EN
      rrExp = (n % 2 == 0) ? 2'b01 : 2'b10;
`else
      rrExp = 2'b01;
`endif
      check($sformatf("t6_grant%0d", n), 128'(lv), 128'(rrExp));
      check($sformatf("t6_latency%0d", n), 128'(lat), (n == 0) ? 128'd18 : 128'd19);
    end

    // Asynchronous reset mid-transfer, checked before any further edge
    repeat (5) @(posedge clkIn);
    #3 resetIn = 1'b0;
    #1 checkReset("arst");
    lineReqIn = '0;
    #20 resetIn = 1'b1;
    repeat (3) @(posedge clkIn);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
